ps_scheduler: RTL and testbench

Time-multiplexed controller for the three ultrasonic parking sensors (index 0 = forward, 1 = rear-left, 2 = rear-right). Fires one sensor at a time in round-robin order so echoes never cross-talk, measures each echo pulse width in clock cycles and keeps a per-sensor proximity flag. Drives the motor driver's stop input (forward sensor) and the buzzer OR-tree (rear sensors).

---
 rtl/ps_scheduler.sv | 179 +++++++++++++++++
 tb/tb_ps_scheduler.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ps_scheduler.sv
// Round-robin ultrasonic parking sensor scheduler: trigger, echo width measurement, proximity flags.
// Optional hysteresis on the near flag is enabled with `define PS_HYST_EN.
module ps_scheduler #(
  parameter int TRIG_CYCLES  = 500,
  parameter int ECHO_TIMEOUT = 1_500_000,
  parameter int GUARD_CYCLES = 250_000,
  parameter int NEAR_THRESH  = 58_000,
  parameter int HYST         = 5_800,
  parameter int W            = 21
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   sensor_en,
  input  logic [2:0]   echo,
  output logic [2:0]   trig,
  output logic [2:0]   near,
  output logic         stop_req,
  output logic         beep,
  output logic         meas_valid,
  output logic [1:0]   meas_id,
  output logic [W-1:0] meas_width,
  output logic         meas_timeout
);

  // state     | meaning
  // IDLE      | pick next enabled sensor after last, load trigger timer
  // TRIG      | trig[sel] high, down-count trigger length
  // WAIT_RISE | count up waiting for echo rising edge
  // MEASURE   | count echo-high cycles until fall or timeout
  // GUARD     | dead time before next selection
  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_GUARD
  } state_t;

  localparam logic [W-1:0] TRIG_LD  = W'(TRIG_CYCLES - 1);
  localparam logic [W-1:0] GUARD_LD = W'(GUARD_CYCLES - 1);
  localparam logic [W-1:0] TIMEOUT  = W'(ECHO_TIMEOUT);

`ifdef PS_HYST_EN
  localparam int HYST_BAND = HYST;
`else
  // Empty band: clear threshold equals set threshold, HYST has no effect.
  localparam int HYST_BAND = HYST * 0;
`endif
  localparam logic [W:0] THR_SET = (W+1)'(NEAR_THRESH);
  localparam logic [W:0] THR_CLR = (W+1)'(NEAR_THRESH + HYST_BAND);

  state_t       state, state_nxt;
  logic [W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [1:0]   sel, sel_nxt;
  logic [1:0]   last, last_nxt;
  logic [2:0]   echo_s1, echo_s2;
  logic [2:0]   near_nxt;
  logic         echo_act, lost;
  logic         done, done_to, abort;
  logic         near_new;

  function automatic logic [1:0] pick_next(input logic [1:0] from, input logic [2:0] en);
    logic [1:0] res;
    int         c;
    res = from;
    // Walk backwards so the nearest successor of 'from' wins.
    for (int k = 3; k >= 1; k--) begin
      c = (int'(from) + k) % 3;
      if (en[c]) res = 2'(c);
    end
    return res;
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel;
    last_nxt  = last;
    done      = 1'b0;
    done_to   = 1'b0;
    abort     = 1'b0;
    echo_act  = echo_s2[sel];
    lost      = !sensor_en[sel];
    cnt_inc   = (&cnt) ? cnt : cnt + W'(1);

    unique case (state)
      S_IDLE: begin
        if (|sensor_en) begin
          sel_nxt   = pick_next(last, sensor_en);
          cnt_nxt   = TRIG_LD;
          state_nxt = S_TRIG;
        end
      end
      S_TRIG: begin
        if (lost) abort = 1'b1;
        else if (cnt == '0) begin
          cnt_nxt   = '0;
          state_nxt = S_WAIT_RISE;
        end else cnt_nxt = cnt - W'(1);
      end
      S_WAIT_RISE: begin
        if (lost) abort = 1'b1;
        else if (echo_act) begin
          cnt_nxt   = W'(1);
          state_nxt = S_MEASURE;
        end else if (cnt_inc >= TIMEOUT) done_to = 1'b1;
        else cnt_nxt = cnt_inc;
      end
      S_MEASURE: begin
        if (lost) abort = 1'b1;
        else if (!echo_act) done = 1'b1;
        else if (cnt_inc >= TIMEOUT) done_to = 1'b1;
        else cnt_nxt = cnt_inc;
      end
      S_GUARD: begin
        if (cnt == '0) state_nxt = S_IDLE;
        else cnt_nxt = cnt - W'(1);
      end
      default: state_nxt = S_IDLE;
    endcase

    if (done || done_to || abort) begin
      state_nxt = S_GUARD;
      cnt_nxt   = GUARD_LD;
      last_nxt  = sel;
    end
  end

  always_comb begin
    near_new = near[sel];
    if (done_to) near_new = 1'b0;
    else if ({1'b0, cnt} < THR_SET) near_new = 1'b1;
    else if ({1'b0, cnt} >= THR_CLR) near_new = 1'b0;

    near_nxt = near;
    if (done || done_to) near_nxt[sel] = near_new;
    near_nxt = near_nxt & sensor_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      sel          <= 2'd0;
      last         <= 2'd2;
      echo_s1      <= 3'b000;
      echo_s2      <= 3'b000;
      near         <= 3'b000;
      meas_valid   <= 1'b0;
      meas_id      <= 2'd0;
      meas_width   <= '0;
      meas_timeout <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sel        <= sel_nxt;
      last       <= last_nxt;
      echo_s1    <= echo;
      echo_s2    <= echo_s1;
      near       <= near_nxt;
      meas_valid <= done | done_to;
      if (done || done_to) begin
        meas_id      <= sel;
        meas_width   <= done_to ? TIMEOUT : cnt;
        meas_timeout <= done_to;
      end
    end
  end

  // Gated by the enable so a disabled sensor's trigger drops without waiting for an edge.
  always_comb begin
    trig = 3'b000;
    if (state == S_TRIG && sensor_en[sel]) trig[sel] = 1'b1;
  end

  assign stop_req = near[0];
  assign beep     = near[1] | near[2];

endmodule

// File: tb/tb_ps_scheduler.sv
// Directed bench for ps_scheduler: vector table of measurements plus disable and reset sequences.
module tb_ps_scheduler;

  localparam int W = 21;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   sensor_en = 3'b000;
  logic [2:0]   echo = 3'b000;
  logic [2:0]   trig;
  logic [2:0]   near;
  logic         stop_req;
  logic         beep;
  logic         meas_valid;
  logic [1:0]   meas_id;
  logic [W-1:0] meas_width;
  logic         meas_timeout;

  int errors = 0;
  int checks = 0;
  int onehot_bad = 0;

  always #5 clk = ~clk;

  ps_scheduler #(
    .TRIG_CYCLES(4), .ECHO_TIMEOUT(200), .GUARD_CYCLES(10),
    .NEAR_THRESH(50), .HYST(10), .W(W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sensor_en(sensor_en), .echo(echo),
    .trig(trig), .near(near), .stop_req(stop_req), .beep(beep),
    .meas_valid(meas_valid), .meas_id(meas_id), .meas_width(meas_width),
    .meas_timeout(meas_timeout)
  );

  always @(negedge clk) if ($countones(trig) > 1) onehot_bad++;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] en;
    int         width;     // 0 = no echo
    int         idx;
    int         exp_width;
    bit         exp_to;
    logic [2:0] exp_near;
  } vec_t;

`ifdef PS_HYST_EN
  localparam logic [2:0] NEAR_55 = 3'b010;
`else
  localparam logic [2:0] NEAR_55 = 3'b000;
`endif

  vec_t vecs[10];

  task automatic run_vec(input vec_t v, input int n);
    int k, lat, idx;
    idx = v.idx;
    sensor_en = v.en;
    k = 0;
    while (trig == 3'b000 && k < 400) begin @(negedge clk); k++; end
    chk($sformatf("v%0d_trig_sel", n), trig, 3'b001 << idx);
    if (trig == 3'b000) return;
    k = 0;
    while (trig != 3'b000 && k < 50) begin @(negedge clk); k++; end
    chk($sformatf("v%0d_trig_len", n), k, 4);
    if (v.width > 0) begin
      repeat (3) @(negedge clk);
      echo[idx] = 1'b1;
      repeat (v.width) @(negedge clk);
      echo[idx] = 1'b0;
    end
    lat = 0;
    do begin @(negedge clk); lat++; end while (!meas_valid && lat < 400);
    chk($sformatf("v%0d_valid", n), meas_valid, 1);
    chk($sformatf("v%0d_latency", n), lat, (v.width > 0) ? 3 : 200);
    chk($sformatf("v%0d_id", n), meas_id, idx);
    chk($sformatf("v%0d_width", n), meas_width, v.exp_width);
    chk($sformatf("v%0d_timeout", n), meas_timeout, v.exp_to);
    chk($sformatf("v%0d_near", n), near, v.exp_near);
    chk($sformatf("v%0d_stop_req", n), stop_req, v.exp_near[0]);
    chk($sformatf("v%0d_beep", n), beep, v.exp_near[1] | v.exp_near[2]);
    @(negedge clk);
    chk($sformatf("v%0d_valid_pulse", n), meas_valid, 0);
  endtask

  initial begin
    int  k;
    bit  seen_valid;

    vecs[0] = '{3'b001,  30, 0,  30, 1'b0, 3'b001};
    vecs[1] = '{3'b111, 100, 1, 100, 1'b0, 3'b001};
    vecs[2] = '{3'b111, 100, 2, 100, 1'b0, 3'b001};
    vecs[3] = '{3'b111, 100, 0, 100, 1'b0, 3'b000};
    vecs[4] = '{3'b010,   0, 1, 200, 1'b1, 3'b000};
    vecs[5] = '{3'b010,  40, 1,  40, 1'b0, 3'b010};
    vecs[6] = '{3'b010,  55, 1,  55, 1'b0, NEAR_55};
    vecs[7] = '{3'b010,  65, 1,  65, 1'b0, 3'b000};
    vecs[8] = '{3'b101,  20, 2,  20, 1'b0, 3'b100};
    vecs[9] = '{3'b101,  45, 0,  45, 1'b0, 3'b101};

    repeat (3) @(negedge clk);
    chk("rst_trig", trig, 0);
    chk("rst_near", near, 0);
    chk("rst_stop_req", stop_req, 0);
    chk("rst_beep", beep, 0);
    chk("rst_meas_valid", meas_valid, 0);
    chk("rst_meas_id", meas_id, 0);
    chk("rst_meas_width", meas_width, 0);
    chk("rst_meas_timeout", meas_timeout, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_trig", trig, 0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Disable sensor 2 while its echo is being measured.
    sensor_en = 3'b100;
    k = 0;
    while (trig == 3'b000 && k < 400) begin @(negedge clk); k++; end
    chk("dis_trig_sel", trig, 3'b100);
    k = 0;
    while (trig != 3'b000 && k < 50) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    echo[2] = 1'b1;
    repeat (10) @(negedge clk);
    sensor_en = 3'b011;
    @(negedge clk);
    chk("dis_near", near, 0);
    chk("dis_trig", trig, 0);
    chk("dis_no_valid_now", meas_valid, 0);
    echo[2] = 1'b0;
    k = 0;
    seen_valid = 1'b0;
    while (trig == 3'b000 && k < 400) begin
      @(negedge clk);
      k++;
      if (meas_valid) seen_valid = 1'b1;
    end
    chk("dis_no_valid", seen_valid, 0);
    chk("dis_next_trig", trig, 3'b001);
    chk("dis_guard_gap", k, 11);

    // Asynchronous reset while trig[0] is high.
    @(negedge clk);
    chk("rstmid_trig_before", trig, 3'b001);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_trig", trig, 0);
    chk("rstmid_valid", meas_valid, 0);
    chk("rstmid_width", meas_width, 0);
    sensor_en = 3'b110;
    repeat (2) @(negedge clk);
    chk("rstmid_hold_trig", trig, 0);
    rst_n = 1'b1;
    k = 0;
    while (trig == 3'b000 && k < 400) begin @(negedge clk); k++; end
    chk("rstmid_first_trig", trig, 3'b010);

    chk("trig_onehot", onehot_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
